// File: rtl/logic16_pkg.sv
// Shared constants, op codes and result type for the 16-bit logic accumulator datapath.
package logic16_pkg;

  localparam int WIDTH = 16;

  localparam logic [2:0] OP_LOAD = 3'd0;
  localparam logic [2:0] OP_NOT  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_NAND = 3'd4;
  localparam logic [2:0] OP_NOR  = 3'd5;
  localparam logic [2:0] OP_XOR  = 3'd6;
  localparam logic [2:0] OP_CLR  = 3'd7;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             zr;
    logic             ng;
  } result_t;

  function automatic result_t make_result(input logic [WIDTH-1:0] data);
    result_t r;
    r.data = data;
    r.zr   = (data == '0);
    r.ng   = data[WIDTH-1];
    return r;
  endfunction

endpackage

// File: rtl/logic16_acc_if.sv
// Command and result handshake bundle between a producer and the logic16 accumulator.
interface logic16_acc_if;
  import logic16_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             zr;
  logic             ng;

  modport master (
    output in_valid, op, b, out_ready,
    input  in_ready, out_valid, out, zr, ng
  );

  modport slave (
    input  in_valid, op, b, out_ready,
    output in_ready, out_valid, out, zr, ng
  );

endinterface

// File: rtl/And16.sv
// 16-bit bitwise AND gate array.
module And16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] out
);
  assign out = a & b;
endmodule

// File: rtl/Not16.sv
// 16-bit bitwise inverter gate array.
module Not16 (
  input  logic [15:0] in,
  output logic [15:0] out
);
  assign out = ~in;
endmodule

// File: rtl/Or16.sv
// 16-bit bitwise OR gate array.
module Or16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] out
);
  assign out = a | b;
endmodule

// File: rtl/logic16_core.sv
// Combinational op function f(op, acc, b) assembled from the Not16/And16/Or16 gate arrays.
module logic16_core
  import logic16_pkg::*;
(
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res
);

  logic [WIDTH-1:0] not_acc, and_ab, or_ab, nand_ab, nor_ab, xor_ab;

  Not16 u_not_acc (.in(acc), .out(not_acc));
  And16 u_and     (.a(acc), .b(b), .out(and_ab));
  Or16  u_or      (.a(acc), .b(b), .out(or_ab));
  Not16 u_nand    (.in(and_ab), .out(nand_ab));
  Not16 u_nor     (.in(or_ab), .out(nor_ab));
  // XOR is "either but not both": (a | b) & ~(a & b)
  And16 u_xor     (.a(or_ab), .b(nand_ab), .out(xor_ab));

  always_comb begin
    res = '0;
    case (op)
      OP_LOAD: res = b;
      OP_NOT:  res = not_acc;
      OP_AND:  res = and_ab;
      OP_OR:   res = or_ab;
      OP_NAND: res = nand_ab;
      OP_NOR:  res = nor_ab;
      OP_XOR:  res = xor_ab;
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/logic16_acc.sv
// Registered 16-bit bitwise accumulator with a valid/ready result buffer.
// Define LOGIC16_SKID_EN for a two-entry buffer with a registered in_ready.
module logic16_acc
  import logic16_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  logic16_acc_if.slave bus
);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] core_res;
  logic [WIDTH-1:0] head_q, head_d;
  logic             accept;
  logic             pop;
  result_t          head_res;

  logic16_core u_core (
    .op  (bus.op),
    .acc (acc_q),
    .b   (bus.b),
    .res (core_res)
  );

  assign accept = bus.in_valid && bus.in_ready;
  assign pop    = bus.out_valid && bus.out_ready;

  always_comb begin
    acc_d = acc_q;
    if (accept) acc_d = core_res;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

`ifdef LOGIC16_SKID_EN
  logic [1:0]       count_q, count_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             full_q, full_d;

  // New results land in the head when it is free (or being freed), else in the skid slot
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    skid_d  = skid_q;
    case ({accept, pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = core_res;
        else                 skid_d = core_res;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        if (count_q == 2'd2) head_d = skid_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd2) begin
          head_d = skid_q;
          skid_d = core_res;
        end else begin
          head_d = core_res;
        end
      end
      default: ;
    endcase
    full_d = (count_d == 2'd2);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      head_q  <= '0;
      skid_q  <= '0;
      full_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
      full_q  <= full_d;
    end
  end

  assign bus.in_ready  = rst_n && !full_q;
  assign bus.out_valid = (count_q != 2'd0);
`else
  logic valid_q, valid_d;

  always_comb begin
    valid_d = valid_q;
    head_d  = head_q;
    if (accept) begin
      valid_d = 1'b1;
      head_d  = core_res;
    end else if (pop) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      head_q  <= '0;
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
    end
  end

  assign bus.in_ready  = rst_n && (!valid_q || bus.out_ready);
  assign bus.out_valid = valid_q;
`endif

  assign head_res = make_result(head_q);
  assign bus.out  = head_res.data;
  assign bus.zr   = head_res.zr;
  assign bus.ng   = head_res.ng;

endmodule

// File: tb/tb_logic16_acc.sv
// Scoreboard bench for logic16_acc: directed scenarios plus random traffic against a reference model.
module tb_logic16_acc;
  import logic16_pkg::*;

  typedef logic [15:0] word_q_t[$];

`ifdef LOGIC16_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic clk;
  logic rst_n;

  logic16_acc_if bus_if ();

  logic16_acc dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int total = 0;
  int bad = 0;
  int acc_cnt = 0;
  int pop_cnt = 0;
  logic [15:0] acc_m = 16'h0;
  logic [15:0] exp_q[$];
  logic [15:0] popped_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] modelOp(input logic [2:0] op, input logic [15:0] a,
                                          input logic [15:0] v);
    case (op)
      3'd0: return v;
      3'd1: return ~a;
      3'd2: return a & v;
      3'd3: return a | v;
      3'd4: return ~(a & v);
      3'd5: return ~(a | v);
      3'd6: return a ^ v;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // One cycle of drive: inputs change 2 time units after the rising edge
  task automatic applyStimulus(input logic v, input logic [2:0] op, input logic [15:0] b,
                               input logic rdy);
    bus_if.in_valid  = v;
    bus_if.op        = op;
    bus_if.b         = b;
    bus_if.out_ready = rdy;
    @(posedge clk);
    #2;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) applyStimulus(1'b0, 3'd0, 16'h0, 1'b1);
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b1);
    checkOutput("drain_empty", 16'(exp_q.size()), 16'd0);
  endtask

  task automatic checkPopped(input string name, input word_q_t e);
    checkOutput({name, "_count"}, 16'(popped_q.size()), 16'(e.size()));
    for (int i = 0; i < e.size() && i < popped_q.size(); i++)
      checkOutput(name, popped_q[i], e[i]);
  endtask

  // Monitor: check the presented result against the scoreboard head, then retire/predict handshakes
  always @(negedge clk) begin
    logic exp_rdy;
    if (!rst_n) begin
      exp_q.delete();
      acc_m = 16'h0;
    end else begin
      checkOutput("out_valid", {15'd0, bus_if.out_valid}, {15'd0, exp_q.size() != 0});
      if (bus_if.out_valid && exp_q.size() != 0) begin
        checkOutput("out", bus_if.out, exp_q[0]);
        checkOutput("zr", {15'd0, bus_if.zr}, {15'd0, exp_q[0] == 16'h0});
        checkOutput("ng", {15'd0, bus_if.ng}, {15'd0, exp_q[0][15]});
      end
`ifdef LOGIC16_SKID_EN
      exp_rdy = exp_q.size() < 2;
`else
      exp_rdy = (exp_q.size() == 0) || bus_if.out_ready;
`endif
      checkOutput("in_ready", {15'd0, bus_if.in_ready}, {15'd0, exp_rdy});
      if (bus_if.out_valid && bus_if.out_ready && exp_q.size() != 0) begin
        popped_q.push_back(bus_if.out);
        void'(exp_q.pop_front());
        pop_cnt++;
      end
      if (bus_if.in_valid && bus_if.in_ready) begin
        acc_m = modelOp(bus_if.op, acc_m, bus_if.b);
        exp_q.push_back(acc_m);
        acc_cnt++;
      end
    end
  end

  initial begin
    int a0, p0;
    word_q_t e;

    // Reset held with a command offered: nothing may be accepted
    rst_n = 1'b0;
    bus_if.in_valid  = 1'b1;
    bus_if.op        = OP_LOAD;
    bus_if.b         = 16'hFFFF;
    bus_if.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #2;
      checkOutput("rst_out_valid", {15'd0, bus_if.out_valid}, 16'd0);
      checkOutput("rst_out", bus_if.out, 16'h0000);
      checkOutput("rst_zr", {15'd0, bus_if.zr}, 16'd1);
      checkOutput("rst_ng", {15'd0, bus_if.ng}, 16'd0);
      checkOutput("rst_in_ready", {15'd0, bus_if.in_ready}, 16'd0);
    end
    rst_n = 1'b1;
    bus_if.in_valid = 1'b0;
    checkOutput("rst_no_accept", 16'(acc_cnt), 16'd0);

    // Chained ops with the consumer always ready
    popped_q.delete();
    applyStimulus(1'b1, OP_LOAD, 16'h00FF, 1'b1);
    applyStimulus(1'b1, OP_OR,   16'h0F00, 1'b1);
    applyStimulus(1'b1, OP_AND,  16'h0FF0, 1'b1);
    applyStimulus(1'b1, OP_NOT,  16'h1234, 1'b1);
    drain();
    e = {16'h00FF, 16'h0FFF, 16'h0FF0, 16'hF00F};
    checkPopped("chain", e);

    popped_q.delete();
    applyStimulus(1'b1, OP_LOAD, 16'hAAAA, 1'b1);
    applyStimulus(1'b1, OP_XOR,  16'hFFFF, 1'b1);
    applyStimulus(1'b1, OP_CLR,  16'h5A5A, 1'b1);
    applyStimulus(1'b1, OP_NAND, 16'h1234, 1'b1);
    applyStimulus(1'b1, OP_NOR,  16'h0000, 1'b1);
    drain();
    e = {16'hAAAA, 16'h5555, 16'h0000, 16'hFFFF, 16'h0000};
    checkPopped("xor_clr", e);

    // Backpressure: three offers while the consumer stalls
    popped_q.delete();
    a0 = acc_cnt;
    applyStimulus(1'b1, OP_LOAD, 16'h1111, 1'b0);
    applyStimulus(1'b1, OP_OR,   16'h0202, 1'b0);
    applyStimulus(1'b1, OP_XOR,  16'h00FF, 1'b0);
    applyStimulus(1'b0, OP_LOAD, 16'h0000, 1'b0);
    checkOutput("bp_accepts", 16'(acc_cnt - a0), 16'(DEPTH));
    drain();
`ifdef LOGIC16_SKID_EN
    e = {16'h1111, 16'h1313};
`else
    e = {16'h1111};
`endif
    checkPopped("bp_drain", e);

    // Pop and accept on the same edge while the buffer holds a result
    popped_q.delete();
    applyStimulus(1'b1, OP_LOAD, 16'h00F0, 1'b0);
    a0 = acc_cnt;
    p0 = pop_cnt;
    applyStimulus(1'b1, OP_OR, 16'h000F, 1'b1);
    checkOutput("simul_accept", 16'(acc_cnt - a0), 16'd1);
    checkOutput("simul_pop", 16'(pop_cnt - p0), 16'd1);
    drain();
    e = {16'h00F0, 16'h00FF};
    checkPopped("simul", e);

    // Reset pulse with results still buffered
    applyStimulus(1'b1, OP_LOAD, 16'h1234, 1'b0);
    applyStimulus(1'b1, OP_NOT,  16'h0000, 1'b0);
    rst_n = 1'b0;
    applyStimulus(1'b0, OP_LOAD, 16'h0000, 1'b0);
    rst_n = 1'b1;
    checkOutput("midrst_out_valid", {15'd0, bus_if.out_valid}, 16'd0);
    checkOutput("midrst_zr", {15'd0, bus_if.zr}, 16'd1);
    popped_q.delete();
    applyStimulus(1'b1, OP_OR, 16'h0001, 1'b1);
    drain();
    e = {16'h0001};
    checkPopped("midrst", e);

    // Random traffic
    for (int i = 0; i < 400; i++)
      applyStimulus(($urandom % 4) != 0, 3'($urandom % 8), 16'($urandom),
                    ($urandom % 3) != 0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
